minn_var_delay_line: RTL and testbench

MINN_VAR_DELAY_LINE -- requirements
Module: minn_var_delay_line

---
 rtl/minn_pkg.sv | 29 ++
 rtl/minn_sdp_ram.sv | 36 +++
 rtl/minn_var_delay_line.sv | 160 ++++++++++++++++
 tb/tb_minn_var_delay_line.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/minn_pkg.sv
// Shared definitions for the minn variable delay line.
//   minn_state_e      : delay-line sequencing state (PRIME / RUN)
//   minn_dw()         : width of a delay / fill count for a given MAX_DEPTH
//   minn_aw()         : address width of a MAX_DEPTH-entry buffer
//   minn_clamp_delay(): maps a requested delay into the legal range 1..MAX_DEPTH
// Delay and count types are built from minn_dw() inside each user, because
// their width follows the MAX_DEPTH parameter of that instance.
package minn_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } minn_state_e;

  function automatic int minn_dw(input int max_depth);
    return $clog2(max_depth + 1);
  endfunction

  function automatic int minn_aw(input int max_depth);
    return (max_depth > 1) ? $clog2(max_depth) : 1;
  endfunction

  function automatic int minn_clamp_delay(input int req, input int max_depth);
    if (req < 1) return 1;
    if (req > max_depth) return max_depth;
    return req;
  endfunction

endpackage

// File: rtl/minn_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read is read-before-write, so reading the address being written returns
// the old word; the delay line relies on this when D equals the depth.
// No reset on the array or the read register, so it maps to block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write word
//   rd_en   : read strobe; rd_data updates only when set
//   rd_addr : read address
//   rd_data : registered read word
module minn_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rd_en) rd_data_q <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/minn_var_delay_line.sv
// Variable delay line: CHANNELS signed lanes sharing one valid and one delay.
// The sample accepted on beat k is presented on accepted beat k+D. After a
// delay change or reset the first D accepted beats are priming beats, which
// output zero (valid only when ZERO_FILL = 1) and never expose buffer data.
//   clk, rst_n   : clock, synchronous active-low reset
//   in_valid     : accept in_data this cycle
//   in_data      : lane samples, lane 0 in the LSBs
//   cfg_valid    : load cfg_delay (clamped to 1..MAX_DEPTH) and re-prime
//   cfg_delay    : requested delay in accepted beats
//   out_valid    : out_data qualified (registered)
//   out_data     : delayed samples (registered)
//   cur_delay    : active delay after clamping
//   cfg_clamped  : one-cycle pulse after an out-of-range cfg_delay
//   priming      : high while in PRIME
//
// state    | meaning
// ST_PRIME | fewer than cur_delay beats accepted since reset/config
// ST_RUN   | buffer holds cur_delay valid samples; outputs carry data
module minn_var_delay_line
  import minn_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int CHANNELS  = 2,
  parameter  int MAX_DEPTH = 64,
  parameter  int ZERO_FILL = 0,
  localparam int DW        = minn_dw(MAX_DEPTH),
  localparam int AW        = minn_aw(MAX_DEPTH),
  localparam int DATA_W    = CHANNELS * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              cfg_valid,
  input  logic [DW-1:0]     cfg_delay,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [DW-1:0]     cur_delay,
  output logic              cfg_clamped,
  output logic              priming
);

  if (MAX_DEPTH < 1) begin : g_err_depth
    $error("minn_var_delay_line: MAX_DEPTH must be >= 1");
  end
  if (CHANNELS < 1) begin : g_err_chan
    $error("minn_var_delay_line: CHANNELS must be >= 1");
  end
  if (WIDTH < 1) begin : g_err_width
    $error("minn_var_delay_line: WIDTH must be >= 1");
  end

  typedef logic [DW-1:0] delay_t;
  typedef logic [AW-1:0] addr_t;
  localparam int SW = AW + 1;

  minn_state_e state_q, state_d;
  delay_t      cur_delay_q, cur_delay_d;
  delay_t      fill_q, fill_d;
  addr_t       wr_ptr_q, wr_ptr_d;
  logic        out_valid_q, out_valid_d;
  logic        out_run_q, out_run_d;
  logic        cfg_clamped_q, cfg_clamped_d;

  minn_state_e st_eff;
  delay_t      fill_eff;
  addr_t       rd_addr;
  logic [SW-1:0] wr_ext, dly_ext;
  logic        ram_we;
  logic [DATA_W-1:0] ram_rd_data;

  // A coincident cfg_valid is applied before the beat is classified, so that
  // beat counts as fill beat 1 of the new delay.
  always_comb begin
    state_d       = state_q;
    cur_delay_d   = cur_delay_q;
    fill_d        = fill_q;
    wr_ptr_d      = wr_ptr_q;
    out_valid_d   = 1'b0;
    out_run_d     = 1'b0;
    cfg_clamped_d = 1'b0;
    st_eff        = state_q;
    fill_eff      = fill_q;

    if (cfg_valid) begin
      cur_delay_d   = delay_t'(minn_clamp_delay(int'(cfg_delay), MAX_DEPTH));
      cfg_clamped_d = (cfg_delay == '0) || (int'(cfg_delay) > MAX_DEPTH);
      st_eff        = ST_PRIME;
      fill_eff      = '0;
    end

    state_d = st_eff;
    fill_d  = fill_eff;

    if (in_valid) begin
      wr_ptr_d = (wr_ptr_q == addr_t'(MAX_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (st_eff == ST_RUN) begin
        out_valid_d = 1'b1;
        out_run_d   = 1'b1;
      end else begin
        fill_d      = fill_eff + 1'b1;
        out_valid_d = (ZERO_FILL != 0);
        if (fill_d >= cur_delay_d) state_d = ST_RUN;
      end
    end
  end

  // Read (wr_ptr - cur_delay) mod MAX_DEPTH; cur_delay is 1..MAX_DEPTH.
  always_comb begin
    wr_ext  = SW'(wr_ptr_q);
    dly_ext = SW'(cur_delay_q);
    if (wr_ext >= dly_ext) rd_addr = AW'(wr_ext - dly_ext);
    else                   rd_addr = AW'(wr_ext + SW'(MAX_DEPTH) - dly_ext);
  end

  assign ram_we = in_valid && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_PRIME;
      cur_delay_q   <= delay_t'(MAX_DEPTH);
      fill_q        <= '0;
      wr_ptr_q      <= '0;
      out_valid_q   <= 1'b0;
      out_run_q     <= 1'b0;
      cfg_clamped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_delay_q   <= cur_delay_d;
      fill_q        <= fill_d;
      wr_ptr_q      <= wr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_run_q     <= out_run_d;
      cfg_clamped_q <= cfg_clamped_d;
    end
  end

  minn_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (ram_we),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // The RAM read register is already aligned with the output beat; masking it
  // with the registered run flag keeps priming beats at zero.
  assign out_data    = out_run_q ? ram_rd_data : '0;
  assign out_valid   = out_valid_q;
  assign cur_delay   = cur_delay_q;
  assign cfg_clamped = cfg_clamped_q;
  assign priming     = (state_q == ST_PRIME);

endmodule

// File: tb/tb_minn_var_delay_line.sv
// Bench for minn_var_delay_line: two instances (ZERO_FILL 0 and 1) share the
// same stimulus and are compared against a sample-history reference model.
module tb_minn_var_delay_line;

  localparam int WIDTH = 16;
  localparam int CH    = 2;
  localparam int MAXD  = 8;
  localparam int DW    = $clog2(MAXD + 1);
  localparam int DWID  = WIDTH * CH;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [DWID-1:0] in_data;
  logic            cfg_valid;
  logic [DW-1:0]   cfg_delay;

  logic            ov0, ov1, cl0, cl1, pr0, pr1;
  logic [DWID-1:0] od0, od1;
  logic [DW-1:0]   cd0, cd1;

  always #5 clk = ~clk;

  minn_var_delay_line #(.WIDTH(WIDTH), .CHANNELS(CH), .MAX_DEPTH(MAXD), .ZERO_FILL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cfg_valid(cfg_valid), .cfg_delay(cfg_delay), .out_valid(ov0), .out_data(od0),
    .cur_delay(cd0), .cfg_clamped(cl0), .priming(pr0));

  minn_var_delay_line #(.WIDTH(WIDTH), .CHANNELS(CH), .MAX_DEPTH(MAXD), .ZERO_FILL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .cfg_valid(cfg_valid), .cfg_delay(cfg_delay), .out_valid(ov1), .out_data(od1),
    .cur_delay(cd1), .cfg_clamped(cl1), .priming(pr1));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted sample is kept in order. A beat is a
  // data beat once more than D beats have been accepted since the last
  // reset/config; its output is the sample accepted D beats earlier.
  logic [DWID-1:0] hist[$];
  int m_d = MAXD;
  int m_n = 0;

  task automatic step(input bit rst, input bit v, input logic [DWID-1:0] d,
                      input bit cv, input int cd);
    bit e_beat, e_run, e_clamp, e_prime;
    logic [DWID-1:0] e_data;
    rst_n     = !rst;
    in_valid  = v;
    in_data   = d;
    cfg_valid = cv;
    cfg_delay = DW'(cd);
    e_beat = 0; e_run = 0; e_clamp = 0; e_data = '0;
    if (rst) begin
      m_d = MAXD;
      m_n = 0;
    end else begin
      if (cv) begin
        m_d = (cd < 1) ? 1 : ((cd > MAXD) ? MAXD : cd);
        m_n = 0;
        e_clamp = (cd < 1) || (cd > MAXD);
      end
      if (v) begin
        e_beat = 1;
        hist.push_back(d);
        m_n++;
        if (m_n > m_d) begin
          e_run  = 1;
          e_data = hist[hist.size() - 1 - m_d];
        end
      end
    end
    e_prime = (m_n < m_d);
    @(posedge clk);
    #1;
    chk("cur_delay0", 32'(cd0), 32'(m_d));
    chk("cur_delay1", 32'(cd1), 32'(m_d));
    chk("priming0", 32'(pr0), 32'(e_prime));
    chk("priming1", 32'(pr1), 32'(e_prime));
    chk("clamped0", 32'(cl0), 32'(e_clamp));
    chk("clamped1", 32'(cl1), 32'(e_clamp));
    chk("out_valid0", 32'(ov0), 32'(e_beat && e_run));
    chk("out_valid1", 32'(ov1), 32'(e_beat));
    if (e_beat || rst) begin
      chk("out_data0", 32'(od0), 32'(e_data));
      chk("out_data1", 32'(od1), 32'(e_data));
    end
  endtask

  task automatic beat(input logic [DWID-1:0] d);
    step(0, 1, d, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_valid = 1'b0; cfg_delay = '0;

    // reset state
    step(1, 0, '0, 0, 0);
    step(1, 1, 32'h1234_5678, 1, 3);

    // D = 4, beats 1..10 on lane 0 (lane 1 distinct)
    step(0, 0, '0, 1, 4);
    for (int i = 1; i <= 10; i++) beat({16'(16'h100 + i), 16'(i)});

    // D change in RUN coinciding with a beat
    step(0, 1, 32'h00AA_0055, 1, 2);
    for (int i = 0; i < 5; i++) beat(32'($urandom));

    // D = 3 with in_valid toggling
    step(0, 0, '0, 1, 3);
    for (int i = 0; i < 20; i++) step(0, i[0] == 1'b0, 32'($urandom), 0, 0);

    // clamping
    step(0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) beat(32'($urandom));
    step(0, 0, '0, 1, MAXD + 1);
    step(0, 1, 32'($urandom), 1, 15);
    step(0, 0, '0, 1, MAXD);

    // D = MAX_DEPTH across pointer wrap, reset mid-stream, full re-prime
    for (int i = 0; i < 21; i++) beat(32'($urandom));
    step(1, 1, 32'($urandom), 1, 2);
    for (int i = 0; i < 20; i++) beat(32'($urandom));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 32'($urandom),
           $urandom_range(0, 29) == 0, int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
